// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment codes {a,b,c,d,e,f,g} and scan FSM state encoding
package seven_seg_pkg;
  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_A   = 7'b1110111;
  localparam logic [6:0] SEG_B   = 7'b0011111;
  localparam logic [6:0] SEG_C   = 7'b1001110;
  localparam logic [6:0] SEG_D   = 7'b0111101;
  localparam logic [6:0] SEG_E   = 7'b1001111;
  localparam logic [6:0] SEG_F   = 7'b1000111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_LUT [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };
  typedef enum logic [1:0] {ST_OFF, ST_COMMIT, ST_SHOW, ST_BLANK} state_e;
endpackage

// File: rtl/seven_seg_hex_decode.sv
// seven_seg_hex_decode: combinational hex nibble to active-high segment pattern
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_LUT[nib_i];
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: multiplexed seven-segment scanner with frame-atomic display commits.
// Optional LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int DWELL_CYCLES = 8,
  parameter  int BLANK_CYCLES = 2,
  localparam int AW           = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dot,
  output logic [6:0]            seg,
  output logic                  dot,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  frame_done
);
  localparam int CW = $clog2(DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES) + 1;
  state_e                state_q;
  logic [AW-1:0]         idx_q;
  logic [CW-1:0]         cnt_q;
  // Shadow spans the full address space so out-of-range writes land in entries nobody displays
  logic [4:0]            shadow_q [2**AW];
  logic [4:0]            display_q [NUM_DIGITS];
  logic [6:0]            seg_q, dec_seg;
  logic                  dot_q, fd_q;
  logic [NUM_DIGITS-1:0] dig_q;
  logic [4:0]            cur;
  logic                  show, dwell_end, blank_end, last_idx, lead_blank;
  assign cur        = display_q[idx_q];
  assign show       = enable && state_q == ST_SHOW;
  assign dwell_end  = cnt_q == CW'(DWELL_CYCLES - 1);
  assign blank_end  = cnt_q == CW'(BLANK_CYCLES - 1);
  assign last_idx   = idx_q == AW'(NUM_DIGITS - 1);
  assign wr_ready   = state_q != ST_COMMIT;
  assign seg        = seg_q;
  assign dot        = dot_q;
  assign dig_sel    = dig_q;
  assign frame_done = fd_q;
  seven_seg_hex_decode u_dec (.nib_i(cur[3:0]), .seg_o(dec_seg));
`ifdef LEAD_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] hi_zero;
  always_comb begin
    logic z;
    z = 1'b1;
    hi_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z & (display_q[i][3:0] == 4'h0);
      hi_zero[i] = z;
    end
  end
  assign lead_blank = idx_q != '0 && hi_zero[idx_q];
`else
  assign lead_blank = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= SEG_OFF;
      dot_q   <= 1'b0;
      dig_q   <= '0;
      fd_q    <= 1'b0;
      for (int i = 0; i < 2**AW; i++) shadow_q[i] <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) display_q[i] <= '0;
    end else begin
      if (wr_valid && wr_ready) shadow_q[wr_addr] <= {wr_dot, wr_data};
      seg_q <= show && !lead_blank ? dec_seg : SEG_OFF;
      dot_q <= show && cur[4];
      dig_q <= show ? NUM_DIGITS'(1) << idx_q : '0;
      fd_q  <= enable && state_q == ST_BLANK && blank_end && last_idx;
      if (!enable) begin
        state_q <= ST_OFF;
        idx_q   <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_OFF: state_q <= ST_COMMIT;
          ST_COMMIT: begin
            for (int i = 0; i < NUM_DIGITS; i++) display_q[i] <= shadow_q[i];
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_SHOW;
          end
          ST_SHOW: begin
            cnt_q <= dwell_end ? '0 : cnt_q + 1'b1;
            if (dwell_end) state_q <= ST_BLANK;
          end
          ST_BLANK: begin
            cnt_q <= blank_end ? '0 : cnt_q + 1'b1;
            if (blank_end) begin
              state_q <= last_idx ? ST_COMMIT : ST_SHOW;
              idx_q   <= last_idx ? '0 : idx_q + 1'b1;
            end
          end
          default: state_q <= ST_OFF;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: frame-position reference model plus directed and random stimulus
module tb_seven_seg_scan_ctrl;
  logic       clk = 0, rst_n = 0, enable = 0, wr_valid = 0, wr_dot = 0;
  logic [1:0] wr_addr = 0;
  logic [3:0] wr_data = 0;
  logic       wr_ready, dot, frame_done;
  logic [6:0] seg;
  logic [3:0] dig_sel;
  logic       e5 = 0, v5 = 0, dt5 = 0, r5, dot5, fd5;
  logic [2:0] a5 = 0;
  logic [3:0] d5 = 0;
  logic [6:0] seg5;
  logic [4:0] sel5;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_dot(wr_dot), .seg(seg), .dot(dot),
    .dig_sel(dig_sel), .frame_done(frame_done)
  );
  seven_seg_scan_ctrl #(.NUM_DIGITS(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .enable(e5), .wr_valid(v5), .wr_ready(r5),
    .wr_addr(a5), .wr_data(d5), .wr_dot(dt5), .seg(seg5), .dot(dot5),
    .dig_sel(sel5), .frame_done(fd5)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
  endtask

  // Reference model: a frame is 41 positions; 0 = commit, then per digit 8 lit + 2 dark.
  localparam logic [6:0] TBL [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [4:0] m_sh [4], m_disp [4];
  bit         m_run = 0, m_ok = 0;
  int         m_pos = 0;
  logic [6:0] e_seg;
  logic [3:0] e_dig;
  logic       e_dot, e_fd;

  function automatic bit lz_blank(input int k);
    bit z = 1;
`ifdef LEAD_ZERO_BLANK_EN
    for (int j = k; j < 4; j++) z = z && (m_disp[j][3:0] == 4'h0);
    return k > 0 && z;
`else
    z = 0;
    return z;
`endif
  endfunction

  always @(posedge clk) begin
    bit lit;
    int k;
    if (!rst_n) begin
      m_ok <= 1; m_run <= 0; m_pos <= 0;
      e_seg <= 0; e_dig <= 0; e_dot <= 0; e_fd <= 0;
      for (int i = 0; i < 4; i++) begin m_sh[i] <= 0; m_disp[i] <= 0; end
    end else begin
      lit = enable && m_run && m_pos >= 1 && ((m_pos - 1) % 10) < 8;
      k = lit ? (m_pos - 1) / 10 : 0;
      e_dig <= lit ? 4'(1 << k) : 4'h0;
      e_seg <= lit && !lz_blank(k) ? TBL[m_disp[k][3:0]] : 7'h0;
      e_dot <= lit && m_disp[k][4];
      e_fd  <= enable && m_run && m_pos == 40;
      if (wr_valid && !(m_run && m_pos == 0)) m_sh[wr_addr] <= {wr_dot, wr_data};
      if (enable && m_run && m_pos == 0) m_disp <= m_sh;
      if (!enable) begin m_run <= 0; m_pos <= 0; end
      else if (!m_run) begin m_run <= 1; m_pos <= 0; end
      else m_pos <= (m_pos + 1) % 41;
    end
  end

  always @(negedge clk) if (m_ok) begin
    chk("seg", seg, e_seg);
    chk("dot", dot, e_dot);
    chk("dig_sel", dig_sel, e_dig);
    chk("frame_done", frame_done, e_fd);
    chk("wr_ready", wr_ready, !(m_run && m_pos == 0));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_dig(input string n, input logic [3:0] d);
    int c = 0;
    while (dig_sel !== d && c < 300) begin cyc(1); c++; end
    if (dig_sel !== d) chk({n, "_timeout"}, dig_sel, d);
  endtask

  task automatic wait_fd(input string n);
    int c = 0;
    cyc(1);
    while (frame_done !== 1'b1 && c < 100) begin cyc(1); c++; end
    if (frame_done !== 1'b1) chk({n, "_timeout"}, frame_done, 1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic t);
    int c = 0;
    wr_valid = 1; wr_addr = a; wr_data = d; wr_dot = t;
    while (!wr_ready && c < 10) begin cyc(1); c++; end
    cyc(1);
    wr_valid = 0;
  endtask

  initial begin
    int c;
    logic [6:0] segs [4];
    logic [6:0] zero_hi;
    int lit5;
`ifdef LEAD_ZERO_BLANK_EN
    zero_hi = 7'b0000000;
`else
    zero_hi = 7'b1111110;
`endif
    cyc(3);
    chk("rst_seg", seg, 0);
    chk("rst_dig", dig_sel, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_fd", frame_done, 0);
    rst_n = 1;
    cyc(2);
    chk("off_dig", dig_sel, 0);
    enable = 1;
    wait_dig("first", 4'b0001);
    chk("first_seg", seg, 7'b1111110);
    wait_fd("fd1");
    c = 0;
    do begin cyc(1); c++; end while (!frame_done && c < 100);
    chk("period", c, 41);
    chk("ready_commit", wr_ready, 0);
    wr_valid = 1; wr_addr = 2; wr_data = 4'h5; wr_dot = 1;
    cyc(1);
    chk("ready_after", wr_ready, 1);
    cyc(1);
    wr_valid = 0;
    wait_dig("cur2", 4'b0100);
    chk("cur2_seg", seg, zero_hi);
    chk("cur2_dot", dot, 0);
    wait_fd("fd2");
    wait_dig("next2", 4'b0100);
    chk("next2_seg", seg, 7'b1011011);
    chk("next2_dot", dot, 1);
    enable = 0;
    cyc(1);
    chk("dis_dig", dig_sel, 0);
    chk("dis_seg", seg, 0);
    chk("dis_dot", dot, 0);
    cyc(3);
    enable = 1;
    c = 0;
    do begin cyc(1); c++; end while (dig_sel == 0 && c < 20);
    chk("reen_first", dig_sel, 4'b0001);
    wr(0, 4'h0, 0); wr(1, 4'h7, 0); wr(2, 4'h0, 0); wr(3, 4'h0, 0);
    wait_fd("fd3");
    wait_fd("fd4");
    for (int i = 0; i < 4; i++) segs[i] = 7'h55;
    for (int i = 0; i < 41; i++) begin
      cyc(1);
      for (int j = 0; j < 4; j++) if (dig_sel[j]) segs[j] = seg;
    end
    chk("lz_d0", segs[0], 7'b1111110);
    chk("lz_d1", segs[1], 7'b1110000);
    chk("lz_d2", segs[2], zero_hi);
    chk("lz_d3", segs[3], zero_hi);
    for (int i = 0; i < 1500; i++) begin
      rst_n    = $urandom_range(0, 499) != 0;
      enable   = $urandom_range(0, 99) < 97;
      wr_valid = $urandom_range(0, 3) == 0;
      wr_addr  = 2'($urandom);
      wr_data  = 4'($urandom);
      wr_dot   = 1'($urandom);
      cyc(1);
    end
    rst_n = 1; wr_valid = 0; enable = 0;
    cyc(2);
    e5 = 1; v5 = 1; a5 = 3'd5; d5 = 4'h8; dt5 = 1;
    c = 0;
    while (!r5 && c < 10) begin cyc(1); c++; end
    chk("oor_hs", r5, 1);
    cyc(1);
    v5 = 0;
    lit5 = 0;
    for (int i = 0; i < 120; i++) begin
      cyc(1);
      if (sel5 != 0) begin
        lit5++;
        chk("oor_seg", seg5, sel5 == 5'b00001 ? 7'b1111110 : zero_hi);
        chk("oor_dot", dot5, 0);
      end
    end
    chk("oor_lit", lit5 > 0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
